analyzer_readout: RTL and testbench

//  Reader side of the logic-analyzer capture RAM. After a capture, the visor MCU starts it to

---
 rtl/analyzer_pkg.sv | 11 +
 rtl/analyzer_readout.sv | 130 +++++++++++++
 tb/tb_analyzer_readout.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/analyzer_pkg.sv
// analyzer_pkg: shared logic-analyzer constants and readout state encoding
//   ANALYZER_ENTRY_W  width of one capture RAM entry {repeat_cnt, sample}
//   SAMPLE_LSB        bit position of the 16-bit sample field
//   REPEAT_LSB        bit position of the 16-bit repeat count field
//   readout_state_t   readout FSM states
package analyzer_pkg;
    localparam int ANALYZER_ENTRY_W = 32;
    localparam int SAMPLE_LSB = 0;
    localparam int REPEAT_LSB = 16;
    typedef enum logic [2:0] {IDLE, READ, WAIT, SEND_LO, SEND_HI, SEND_SUM} readout_state_t;
endpackage

// File: rtl/analyzer_readout.sv
// analyzer_readout: streams capture RAM run-length entries as 16-bit words plus a zero-sum checksum
//   sysclk, sysreset       clock, synchronous active-high reset
//   start, abort           one-cycle control pulses from the MCU
//   entry_count            entries to read, sampled on an accepted start
//   busy, done             readout in progress / one-cycle completion pulse
//   ram_addr, ram_rden     capture RAM read port (data returns on ram_q next cycle)
//   ram_q                  RAM read data {repeat_cnt, sample}
//   out_data, out_valid    stream word and its valid
//   out_last, out_ready    checksum marker / MCU accept
module analyzer_readout
    import analyzer_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic                        sysclk,
    input  logic                        sysreset,
    input  logic                        start,
    input  logic                        abort,
    input  logic [ADDR_W:0]             entry_count,
    output logic                        busy,
    output logic                        done,
    output logic [ADDR_W-1:0]           ram_addr,
    output logic                        ram_rden,
    input  logic [ANALYZER_ENTRY_W-1:0] ram_q,
    output logic [15:0]                 out_data,
    output logic                        out_valid,
    output logic                        out_last,
    input  logic                        out_ready
);
    readout_state_t state;
    logic [ADDR_W:0] remaining;
    logic [15:0]     repeat_hold;
    logic [15:0]     sum;
    logic            xfer;
    logic [15:0]     sum_next;

    assign xfer     = out_valid && out_ready;
    assign sum_next = sum + out_data;

    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            state       <= IDLE;
            remaining   <= '0;
            repeat_hold <= '0;
            sum         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            ram_addr    <= '0;
            ram_rden    <= 1'b0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
        end else if (abort) begin
            // A word transferred in this same cycle is still dropped from the checksum path.
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            ram_addr  <= '0;
            ram_rden  <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        remaining <= entry_count;
                        sum       <= '0;
                        busy      <= 1'b1;
                        if (entry_count != '0) begin
                            state    <= READ;
                            ram_rden <= 1'b1;
                        end else begin
                            // Empty capture: checksum of nothing is 0.
                            state     <= SEND_SUM;
                            out_data  <= '0;
                            out_valid <= 1'b1;
                            out_last  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    ram_rden <= 1'b0;
                    state    <= WAIT;
                end
                WAIT: begin
                    // Only the repeat half is kept; the sample goes straight to the output.
                    repeat_hold <= ram_q[REPEAT_LSB +: 16];
                    out_data    <= ram_q[SAMPLE_LSB +: 16];
                    out_valid   <= 1'b1;
                    state       <= SEND_LO;
                end
                SEND_LO: begin
                    if (xfer) begin
                        sum      <= sum_next;
                        out_data <= repeat_hold;
                        state    <= SEND_HI;
                    end
                end
                SEND_HI: begin
                    if (xfer) begin
                        sum       <= sum_next;
                        ram_addr  <= ram_addr + ADDR_W'(1);
                        remaining <= remaining - (ADDR_W+1)'(1);
                        if (remaining == (ADDR_W+1)'(1)) begin
                            state    <= SEND_SUM;
                            out_data <= 16'h0 - sum_next;
                            out_last <= 1'b1;
                        end else begin
                            state     <= READ;
                            out_valid <= 1'b0;
                            ram_rden  <= 1'b1;
                        end
                    end
                end
                SEND_SUM: begin
                    if (xfer) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        ram_addr  <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_analyzer_readout.sv
// tb_analyzer_readout: randomized self-checking bench for analyzer_readout against a word-list model
module tb_analyzer_readout;
    localparam int AW = 4;

    logic          sysclk = 1'b0;
    logic          sysreset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW:0]   entry_count = '0;
    logic          busy, done, ram_rden, out_valid, out_last;
    logic          out_ready = 1'b1;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_q = '0;
    logic [15:0]   out_data;

    logic [31:0]   mem [16];
    logic [16:0]   wq[$];
    logic [16:0]   exp_q[$];
    logic [AW-1:0] rq[$];
    int            checks = 0;
    int            failures = 0;
    int            done_cnt = 0;
    int            viol = 0;
    int            cyc = 0;
    int            start_cyc = 0;
    int            first_rd = -1;
    int            first_val = -1;
    logic          pend = 1'b0;
    logic [16:0]   pword = '0;

    analyzer_readout #(.ADDR_W(AW)) dut (
        .sysclk(sysclk), .sysreset(sysreset), .start(start), .abort(abort),
        .entry_count(entry_count), .busy(busy), .done(done), .ram_addr(ram_addr),
        .ram_rden(ram_rden), .ram_q(ram_q), .out_data(out_data), .out_valid(out_valid),
        .out_last(out_last), .out_ready(out_ready)
    );

    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) if (ram_rden) ram_q <= mem[ram_addr];

    always @(negedge sysclk) begin
        if (!sysreset) begin
            if (out_valid && out_ready) wq.push_back({out_last, out_data});
            if (ram_rden) rq.push_back(ram_addr);
            if (done) done_cnt++;
            if (pend && !(out_valid && {out_last, out_data} == pword)) viol++;
            if (start && !busy) start_cyc = cyc;
            if (ram_rden && first_rd < 0) first_rd = cyc - start_cyc;
            if (out_valid && first_val < 0) first_val = cyc - start_cyc;
        end
        pend  = out_valid && !out_ready && !abort && !sysreset;
        pword = {out_last, out_data};
        cyc++;
    end

    task automatic model(input int n);
        logic [15:0] s;
        s = '0;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({1'b0, mem[i][15:0]});
            exp_q.push_back({1'b0, mem[i][31:16]});
            s = s + mem[i][15:0] + mem[i][31:16];
        end
        exp_q.push_back({1'b1, 16'h0 - s});
    endtask

    function automatic bit words_ok();
        if (wq.size() != exp_q.size()) return 1'b0;
        foreach (wq[i]) if (wq[i] !== exp_q[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit reads_ok(input int n);
        if (rq.size() != n) return 1'b0;
        foreach (rq[i]) if (int'(rq[i]) != i) return 1'b0;
        return 1'b1;
    endfunction

    task automatic clear_mon();
        wq.delete();
        rq.delete();
        done_cnt = 0;
        viol = 0;
        first_rd = -1;
        first_val = -1;
    endtask

    task automatic pulse_start(input int n);
        @(posedge sysclk); #1;
        entry_count = (AW+1)'(n);
        start = 1'b1;
        @(posedge sysclk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input bit rnd, output bit timeout);
        timeout = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (done_cnt != 0) begin
                timeout = 1'b0;
                break;
            end
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            @(posedge sysclk); #1;
        end
        out_ready = 1'b1;
        repeat (2) @(posedge sysclk);
        #1;
    endtask

    task automatic run(input int n, input bit rnd, output bit timeout);
        clear_mon();
        model(n);
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        pulse_start(n);
        wait_done(rnd, timeout);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge sysclk);
        @(negedge sysclk);
        checks++;
        if ({busy, done, out_valid, out_last, ram_rden, ram_addr, out_data} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=0", {busy, done, out_valid, out_last, ram_rden, ram_addr, out_data});
        end
        @(posedge sysclk); #1;
        sysreset = 1'b0;
    endtask

    task automatic test_zero_count();
        bit to;
        run(0, 1'b0, to);
        checks++;
        if (to || !words_ok()) begin
            failures++;
            $display("FAIL zero_words got=%0d words first=%h want=1 word %h timeout=%0d", wq.size(), wq.size() ? wq[0] : 17'h0, exp_q[0], to);
        end
        checks++;
        if (rq.size() != 0) begin
            failures++;
            $display("FAIL zero_no_read got=%0d reads want=0", rq.size());
        end
        checks++;
        if (done_cnt != 1) begin
            failures++;
            $display("FAIL zero_done got=%0d want=1", done_cnt);
        end
    endtask

    task automatic test_basic();
        bit to;
        logic [15:0] s;
        mem[0] = 32'h0003_1234;
        mem[1] = 32'h0000_ABCD;
        run(2, 1'b0, to);
        checks++;
        if (to || !words_ok()) begin
            failures++;
            $display("FAIL basic_words got=%0d words want=%0d timeout=%0d", wq.size(), exp_q.size(), to);
        end
        s = '0;
        foreach (wq[i]) s = s + wq[i][15:0];
        checks++;
        if (s !== 16'h0 || wq.size() != 5) begin
            failures++;
            $display("FAIL basic_zero_sum got=%h over %0d words want=0000 over 5", s, wq.size());
        end
        checks++;
        if (first_rd != 1 || first_val != 3) begin
            failures++;
            $display("FAIL basic_latency got rden=%0d valid=%0d want rden=1 valid=3", first_rd, first_val);
        end
        checks++;
        if (!reads_ok(2)) begin
            failures++;
            $display("FAIL basic_reads got=%0d want=2", rq.size());
        end
    endtask

    task automatic test_backpressure();
        bit to;
        run(2, 1'b1, to);
        checks++;
        if (to || !words_ok()) begin
            failures++;
            $display("FAIL bp_words got=%0d words want=%0d timeout=%0d", wq.size(), exp_q.size(), to);
        end
        checks++;
        if (viol != 0) begin
            failures++;
            $display("FAIL bp_stable got=%0d violations want=0", viol);
        end
    endtask

    task automatic test_random();
        bit to;
        int n;
        for (int it = 0; it < 5; it++) begin
            foreach (mem[i]) mem[i] = $urandom;
            n = $urandom_range(1, 15);
            run(n, 1'b1, to);
            checks++;
            if (to || !words_ok() || !reads_ok(n) || viol != 0) begin
                failures++;
                $display("FAIL random_%0d got=%0d words %0d reads viol=%0d want=%0d words %0d reads", it, wq.size(), rq.size(), viol, exp_q.size(), n);
            end
        end
    endtask

    task automatic test_abort();
        bit to;
        clear_mon();
        out_ready = 1'b1;
        pulse_start(3);
        for (int c = 0; c < 50 && wq.size() < 2; c++) begin
            @(posedge sysclk); #1;
        end
        abort = 1'b1;
        @(posedge sysclk); #1;
        abort = 1'b0;
        @(negedge sysclk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle got valid=%b busy=%b want 0 0", out_valid, busy);
        end
        repeat (8) @(posedge sysclk);
        #1;
        checks++;
        if (done_cnt != 0 || wq.size() != 2) begin
            failures++;
            $display("FAIL abort_no_done got done=%0d words=%0d want done=0 words=2", done_cnt, wq.size());
        end
        run(1, 1'b0, to);
        checks++;
        if (to || !reads_ok(1) || !words_ok()) begin
            failures++;
            $display("FAIL abort_restart got reads=%0d addr0=%0d words=%0d want 1 read at 0, %0d words", rq.size(), rq.size() ? rq[0] : '0, wq.size(), exp_q.size());
        end
    endtask

    task automatic test_start_busy();
        bit to;
        foreach (mem[i]) mem[i] = $urandom;
        clear_mon();
        model(2);
        out_ready = 1'b0;
        pulse_start(2);
        repeat (3) @(posedge sysclk);
        #1;
        entry_count = (AW+1)'(5);
        start = 1'b1;
        @(posedge sysclk); #1;
        start = 1'b0;
        out_ready = 1'b1;
        wait_done(1'b0, to);
        checks++;
        if (to || !words_ok() || !reads_ok(2)) begin
            failures++;
            $display("FAIL start_busy got=%0d words %0d reads want=%0d words 2 reads", wq.size(), rq.size(), exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        pulse_start(3);
        repeat (5) @(posedge sysclk);
        #1;
        sysreset = 1'b1;
        @(posedge sysclk); #1;
        @(negedge sysclk);
        checks++;
        if ({busy, done, out_valid, out_last, ram_rden, ram_addr, out_data} !== '0) begin
            failures++;
            $display("FAIL reset_mid got=%b want=0", {busy, done, out_valid, out_last, ram_rden, ram_addr, out_data});
        end
        @(posedge sysclk); #1;
        sysreset = 1'b0;
    endtask

    task automatic test_full();
        bit to;
        int lasts;
        foreach (mem[i]) mem[i] = {16'(i), 16'(16'h100 + i)};
        run(16, 1'b0, to);
        checks++;
        if (to || !reads_ok(16)) begin
            failures++;
            $display("FAIL full_reads got=%0d want=16 at 0..15 timeout=%0d", rq.size(), to);
        end
        lasts = 0;
        foreach (wq[i]) if (wq[i][16]) lasts++;
        checks++;
        if (!words_ok() || wq.size() != 33 || lasts != 1) begin
            failures++;
            $display("FAIL full_words got=%0d words %0d last want=33 words 1 last", wq.size(), lasts);
        end
        checks++;
        if (ram_addr !== '0) begin
            failures++;
            $display("FAIL full_addr_end got=%0d want=0", ram_addr);
        end
    endtask

    initial begin
        foreach (mem[i]) mem[i] = '0;
        test_reset();
        test_zero_count();
        test_basic();
        test_backpressure();
        test_random();
        test_abort();
        test_start_busy();
        test_reset_mid();
        test_full();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
